// File: rtl/mul_div_unit_if.sv
// Handshake/operand bundle between the instruction control decoder and the
// HI/LO multiply/divide unit. The decoder side drives start/op/operands and
// observes busy/done/results; the unit side is the mirror image.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       div_mul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, div_mul, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, div_mul, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Ops: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. One result bit per CALC cycle,
// sign correction in FIX, results published in DONE with a one-cycle done.
// Optional build macro MDU_EARLY_TERM_EN: multiplies leave CALC as soon as the
// remaining multiplier bits are all zero (divides keep fixed latency).
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mul_div_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // Operation context captured at the start edge
  logic             r_isDiv;
  logic             r_negRes;
  logic             r_negRem;
  logic             r_bZero;
  logic [WIDTH-1:0] r_aRaw;
  logic [CW-1:0]    r_count;

  // Multiplier datapath: shifted multiplicand, consumed multiplier, product
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;

  // Divider datapath: partial remainder, dividend/quotient shifter, divisor
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_divisor;

  // Registered outputs
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_aAbs;
  logic [WIDTH-1:0] w_bAbs;
  logic [2*WIDTH-1:0] w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH:0]   w_divTrial;
  logic             w_lastIter;

  // Signed ops work on magnitudes; the most negative value maps to its unsigned magnitude
  assign w_aNeg = bus.div_mul[0] & bus.a[WIDTH-1];
  assign w_bNeg = bus.div_mul[0] & bus.b[WIDTH-1];
  assign w_aAbs = w_aNeg ? -bus.a : bus.a;
  assign w_bAbs = w_bNeg ? -bus.b : bus.b;

  // Shift-add step and restoring-division trial subtract (bit WIDTH is the trial sign)
  assign w_mulSum   = r_acc + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});
  assign w_divShift = {r_rem, r_quot[WIDTH-1]};
  assign w_divTrial = w_divShift - {1'b0, r_divisor};

`ifdef MDU_EARLY_TERM_EN
  assign w_lastIter = (r_count == CW'(WIDTH - 1)) ||
                      (!r_isDiv && (r_mplier[WIDTH-1:1] == '0));
`else
  assign w_lastIter = (r_count == CW'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: start is only honoured in IDLE, so busy/DONE starts are dropped
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_CALC;
      S_CALC: if (w_lastIter) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands, iterate one bit per cycle, then apply result signs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_bZero   <= 1'b0;
      r_aRaw    <= '0;
      r_count   <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_isDiv   <= bus.div_mul[1];
            r_negRes  <= w_aNeg ^ w_bNeg;
            r_negRem  <= w_aNeg;
            r_bZero   <= (bus.b == '0);
            r_aRaw    <= bus.a;
            r_count   <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, w_aAbs};
            r_mplier  <= w_bAbs;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quot    <= w_aAbs;
            r_divisor <= w_bAbs;
          end
        end
        S_CALC: begin
          r_count <= r_count + 1'b1;
          if (r_isDiv) begin
            if (!w_divTrial[WIDTH]) begin
              r_rem  <= w_divTrial[WIDTH-1:0];
              r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
              r_rem  <= w_divShift[WIDTH-1:0];
              r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc    <= w_mulSum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        S_FIX: begin
          if (r_isDiv) begin
            if (r_bZero) begin
              r_quot <= '1;
              r_rem  <= r_aRaw;
            end else begin
              r_quot <= r_negRes ? -r_quot : r_quot;
              r_rem  <= r_negRem ? -r_rem : r_rem;
            end
          end else begin
            r_acc <= r_negRes ? -r_acc : r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs lag the state by one edge; HI/LO only update on the DONE edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= (r_state == S_CALC) || (r_state == S_FIX);
      r_done <= (r_state == S_DONE);
      r_dbz  <= (r_state == S_DONE) && r_isDiv && r_bZero;
      if (r_state == S_DONE) begin
        r_hi <= r_isDiv ? r_rem  : r_acc[2*WIDTH-1:WIDTH];
        r_lo <= r_isDiv ? r_quot : r_acc[WIDTH-1:0];
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a table of directed operations with
// hand-computed HI/LO results, plus sequences for ignored starts and mid-op reset.
module tb_mul_div_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDbz;
  } vec_t;

  logic clk;
  logic rst;

  mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int errors;

  logic [31:0] gotHi;
  logic [31:0] gotLo;
  logic        gotDbz;
  int          gotLat;
  logic        busyEarly;
  logic        busyAtDone;
  logic        doneAfter;

  vec_t vecs[16];

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, reports a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Expected start-to-done latency in cycles
  function automatic int expLatency(input logic [1:0] op, input logic [31:0] b);
    int n;
    logic [31:0] mag;
    n = WIDTH;
`ifdef MDU_EARLY_TERM_EN
    if (!op[1]) begin
      mag = (op[0] && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < WIDTH; i++) begin
        if (mag[i]) n = i + 1;
      end
    end
`else
    mag = b;
    if (op[1] && mag[0]) n = WIDTH;
`endif
    return n + 2;
  endfunction

  // Issue one op for a single start edge, scramble the inputs, then wait for done
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic seen;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.div_mul = op;
    bus.a       = a;
    bus.b       = b;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.a       = $urandom;
    bus.b       = $urandom;
    bus.div_mul = 2'($urandom);
    gotLat     = 0;
    seen       = 1'b0;
    busyEarly  = 1'b0;
    busyAtDone = 1'b1;
    while (!seen && gotLat < 200) begin
      @(posedge clk);
      #1;
      gotLat++;
      if (gotLat == 1) busyEarly = bus.busy;
      if (bus.done) begin
        seen       = 1'b1;
        gotHi      = bus.hi;
        gotLo      = bus.lo;
        gotDbz     = bus.div_by_zero;
        busyAtDone = bus.busy;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done timeout: got no done in 200 cycles, expected one");
    end
    @(posedge clk);
    #1;
    doneAfter = bus.done;
  endtask

  initial begin
    int doneCount;

    checks = 0;
    errors = 0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[5]  = '{2'b10, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[12] = '{2'b00, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0000000F, 1'b0};
    vecs[13] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[14] = '{2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[15] = '{2'b10, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};

    bus.start   = 1'b0;
    bus.div_mul = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    rst         = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset dbz",  64'(bus.div_by_zero), 64'd0);
    checkOutput("reset hi",   64'(bus.hi), 64'd0);
    checkOutput("reset lo",   64'(bus.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("v%0d hi", i),        64'(gotHi),  64'(vecs[i].expHi));
      checkOutput($sformatf("v%0d lo", i),        64'(gotLo),  64'(vecs[i].expLo));
      checkOutput($sformatf("v%0d dbz", i),       64'(gotDbz), 64'(vecs[i].expDbz));
      checkOutput($sformatf("v%0d latency", i),   64'(gotLat), 64'(expLatency(vecs[i].op, vecs[i].b)));
      checkOutput($sformatf("v%0d busy early", i), 64'(busyEarly), 64'd1);
      checkOutput($sformatf("v%0d busy at done", i), 64'(busyAtDone), 64'd0);
      checkOutput($sformatf("v%0d done width", i), 64'(doneAfter), 64'd0);
    end

    // Second start during an op is ignored: MULTU 6*7 with a DIV request at cycle 5
    doneCount = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.div_mul = 2'b00;
    bus.a       = 32'd6;
    bus.b       = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.div_mul = 2'b11;
    bus.a       = 32'd100;
    bus.b       = 32'd100;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (bus.done) begin
      doneCount++;
      gotHi = bus.hi;
      gotLo = bus.lo;
    end
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        doneCount++;
        gotHi = bus.hi;
        gotLo = bus.lo;
      end
    end
    checkOutput("ignored start done count", 64'(doneCount), 64'd1);
    checkOutput("ignored start lo", 64'(gotLo), 64'd42);
    checkOutput("ignored start hi", 64'(gotHi), 64'd0);

    // Reset at cycle 10 of a DIVU: op is lost, outputs cleared, no done afterwards
    @(negedge clk);
    bus.start   = 1'b1;
    bus.div_mul = 2'b10;
    bus.a       = 32'd1000;
    bus.b       = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("pre-reset busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid-op reset busy", 64'(bus.busy), 64'd0);
    checkOutput("mid-op reset hi",   64'(bus.hi), 64'd0);
    checkOutput("mid-op reset lo",   64'(bus.lo), 64'd0);
    doneCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) doneCount++;
    end
    checkOutput("mid-op reset no done", 64'(doneCount), 64'd0);

    // Fresh op after the aborted one
    applyStimulus(2'b00, 32'd2, 32'd3);
    checkOutput("post-reset lo", 64'(gotLo), 64'd6);
    checkOutput("post-reset hi", 64'(gotHi), 64'd0);
    checkOutput("post-reset latency", 64'(gotLat), 64'(expLatency(2'b00, 32'd3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
